pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register for the 6-stage MIPS32 core;

---
 rtl/mips_pipe_pkg.sv | 43 ++++
 rtl/pipe_stage_reg_sat_counter.sv | 31 +++
 rtl/pipe_stage_reg.sv | 109 ++++++++++
 tb/tb_pipe_stage_reg.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions for the 6-stage MIPS32 core: stall vector
// width, stage index constants, stall vector type and the per-cycle update
// decision used by the inter-stage registers.
package mips_pipe_pkg;

  localparam int STALL_W = 6;

  // Stage indices into the stall vector; stall[i+1] is the stage after stall[i].
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  typedef logic [STALL_W-1:0] stall_t;

  // What a pipeline register does on the coming clock edge.
  typedef enum logic [2:0] {
    OP_RESET   = 3'd0,
    OP_FLUSH   = 3'd1,
    OP_BUBBLE  = 3'd2,
    OP_HOLD    = 3'd3,
    OP_ADVANCE = 3'd4
  } stage_op_e;

  // Priority: reset, then flush (ignores stall), then bubble/hold, then advance.
  // A bubble is inserted when this stage stalls but the downstream one does
  // not, so downstream must not see this stage's contents twice.
  function automatic stage_op_e decode_op(input logic rst,
                                          input logic flush,
                                          input logic s_here,
                                          input logic s_next);
    stage_op_e op;
    if (rst)                   op = OP_RESET;
    else if (flush)            op = OP_FLUSH;
    else if (s_here && !s_next) op = OP_BUBBLE;
    else if (s_here)           op = OP_HOLD;
    else                       op = OP_ADVANCE;
    return op;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
// Latency: count visible the cycle after the inc cycle.
// Backpressure: none; inc is sampled every cycle.
// Ports: clk, rst (sync, active-high), inc (count this cycle), cnt (value).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall/flush policy (bubble, hold, advance)
// Latency: 1 cycle input->output on advance; no combinational in->out path.
// Backpressure: stall[STAGE_IDX] holds or bubbles depending on stall[STAGE_IDX+1].
// Ports: clk, rst (sync, active-high); stall vector, flush; valid_i/ctrl_i/
//   payload_i in; valid_o/ctrl_o/payload_o registered out; bubble_cnt and
//   flush_cnt saturating profiling counters.
module pipe_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int STAGE_IDX   = STG_MEM,
  parameter int STALL_W     = mips_pipe_pkg::STALL_W,
  parameter int PAYLOAD_W   = 64,
  parameter int CTRL_W      = 4,
  parameter bit CLR_PAYLOAD = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic                 valid_i,
  input  logic [CTRL_W-1:0]    ctrl_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic                 valid_o,
  output logic [CTRL_W-1:0]    ctrl_o,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  logic s_here;
  logic s_next;

  // Only two stall bits matter to this stage; the rest are ignored on purpose.
  logic unused_stall;
  assign unused_stall = ^stall;

  if (STAGE_IDX >= STALL_W) begin : g_bad_stage_idx
    // Only elaborated for an illegal configuration, so it never reaches silicon.
    initial $error("pipe_stage_reg: STAGE_IDX (%0d) must be < STALL_W (%0d)",
                   STAGE_IDX, STALL_W);
    assign s_here = 1'b0;
    assign s_next = 1'b0;
  end else if (STAGE_IDX == STALL_W - 1) begin : g_last_stage
    // Last stage has nothing downstream that could stall it.
    assign s_here = stall[STAGE_IDX];
    assign s_next = 1'b0;
  end else begin : g_mid_stage
    assign s_here = stall[STAGE_IDX];
    assign s_next = stall[STAGE_IDX+1];
  end

  stage_op_e            op;
  logic                 valid_q,   valid_d;
  logic [CTRL_W-1:0]    ctrl_q,    ctrl_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;

  always_comb begin
    op        = decode_op(rst, flush, s_here, s_next);
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    payload_d = payload_q;
    case (op)
      OP_RESET: begin
        valid_d   = 1'b0;
        ctrl_d    = '0;
        payload_d = '0;
      end
      OP_FLUSH, OP_BUBBLE: begin
        valid_d = 1'b0;
        ctrl_d  = '0;
        // Holding the payload avoids toggling wide datapath flops for nothing.
        if (CLR_PAYLOAD) payload_d = '0;
      end
      OP_ADVANCE: begin
        valid_d   = valid_i;
        // Write enables of an invalid slot must never reach later stages.
        ctrl_d    = ctrl_i & {CTRL_W{valid_i}};
        payload_d = payload_i;
      end
      default: ;  // OP_HOLD keeps everything
    endcase
  end

  always_ff @(posedge clk) begin
    valid_q   <= valid_d;
    ctrl_q    <= ctrl_d;
    payload_q <= payload_d;
  end

  assign valid_o   = valid_q;
  assign ctrl_o    = ctrl_q;
  assign payload_o = payload_q;

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (op == OP_BUBBLE),
    .cnt (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (op == OP_FLUSH),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        valid_i;
  logic [3:0]  ctrl_i;
  logic [63:0] payload_i;

  // a: defaults (STAGE_IDX=4, clear payload, 16-bit counters)
  logic        a_valid;  logic [3:0] a_ctrl;  logic [63:0] a_pay;
  logic [15:0] a_bub, a_fl;
  // b: payload held on bubble/flush
  logic        b_valid;  logic [3:0] b_ctrl;  logic [63:0] b_pay;
  logic [15:0] b_bub, b_fl;
  // c: 2-bit counters for saturation
  logic        c_valid;  logic [3:0] c_ctrl;  logic [63:0] c_pay;
  logic [1:0]  c_bub, c_fl;
  // d: last stage (STAGE_IDX=5, no downstream stall)
  logic        d_valid;  logic [3:0] d_ctrl;  logic [63:0] d_pay;
  logic [15:0] d_bub, d_fl;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.STAGE_IDX(4)) u_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_i(valid_i),
    .ctrl_i(ctrl_i), .payload_i(payload_i), .valid_o(a_valid), .ctrl_o(a_ctrl),
    .payload_o(a_pay), .bubble_cnt(a_bub), .flush_cnt(a_fl));

  pipe_stage_reg #(.STAGE_IDX(4), .CLR_PAYLOAD(1'b0)) u_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_i(valid_i),
    .ctrl_i(ctrl_i), .payload_i(payload_i), .valid_o(b_valid), .ctrl_o(b_ctrl),
    .payload_o(b_pay), .bubble_cnt(b_bub), .flush_cnt(b_fl));

  pipe_stage_reg #(.STAGE_IDX(4), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_i(valid_i),
    .ctrl_i(ctrl_i), .payload_i(payload_i), .valid_o(c_valid), .ctrl_o(c_ctrl),
    .payload_o(c_pay), .bubble_cnt(c_bub), .flush_cnt(c_fl));

  pipe_stage_reg #(.STAGE_IDX(5)) u_d (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_i(valid_i),
    .ctrl_i(ctrl_i), .payload_i(payload_i), .valid_o(d_valid), .ctrl_o(d_ctrl),
    .payload_o(d_pay), .bubble_cnt(d_bub), .flush_cnt(d_fl));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs are changed right after this returns, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    stall     = 6'($urandom);
    flush     = 1'($urandom);
    valid_i   = 1'($urandom);
    ctrl_i    = 4'($urandom);
    payload_i = {$urandom, $urandom};
  endtask

  initial begin
    // Reset for two cycles with random inputs; second cycle forces flush+bubble
    rst = 1'b1;
    rand_inputs();
    tick();
    rand_inputs();
    flush = 1'b1;
    stall = 6'b011111;
    tick();
    check("rst_valid",  64'(a_valid), 64'd0);
    check("rst_ctrl",   64'(a_ctrl),  64'd0);
    check("rst_pay",    a_pay,        64'd0);
    check("rst_bub",    64'(a_bub),   64'd0);
    check("rst_fl",     64'(a_fl),    64'd0);
    check("rst_b_pay",  b_pay,        64'd0);
    check("rst_c_bub",  64'(c_bub),   64'd0);
    check("rst_d_fl",   64'(d_fl),    64'd0);

    // Advance
    rst = 1'b0; flush = 1'b0; stall = 6'b000000;
    valid_i = 1'b1; ctrl_i = 4'b1011; payload_i = 64'hDEAD_BEEF;
    tick();
    check("adv_valid", 64'(a_valid), 64'd1);
    check("adv_ctrl",  64'(a_ctrl),  64'hB);
    check("adv_pay",   a_pay,        64'hDEAD_BEEF);

    // Bubble: stage 4 stalls, stage 5 does not
    stall = 6'b011111;
    tick();
    check("bub_valid",   64'(a_valid), 64'd0);
    check("bub_ctrl",    64'(a_ctrl),  64'd0);
    check("bub_pay",     a_pay,        64'd0);
    check("bub_cnt",     64'(a_bub),   64'd1);
    check("bub_fl",      64'(a_fl),    64'd0);
    check("bub_b_valid", 64'(b_valid), 64'd0);
    check("bub_b_pay",   b_pay,        64'hDEAD_BEEF);
    check("bub_d_valid", 64'(d_valid), 64'd1);
    check("bub_d_pay",   d_pay,        64'hDEAD_BEEF);

    // Load 0x1234 then hold for 3 cycles while inputs change
    stall = 6'b000000; valid_i = 1'b1; ctrl_i = 4'b0101; payload_i = 64'h1234;
    tick();
    check("load_pay", a_pay, 64'h1234);
    stall = 6'b111111; valid_i = 1'b0; ctrl_i = 4'hF; payload_i = 64'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valid", 64'(a_valid), 64'd1);
      check("hold_ctrl",  64'(a_ctrl),  64'h5);
      check("hold_pay",   a_pay,        64'h1234);
      check("hold_bub",   64'(a_bub),   64'd1);
      check("hold_fl",    64'(a_fl),    64'd0);
    end

    // Flush wins over full stall
    flush = 1'b1;
    tick();
    check("fl_valid",   64'(a_valid), 64'd0);
    check("fl_ctrl",    64'(a_ctrl),  64'd0);
    check("fl_pay",     a_pay,        64'd0);
    check("fl_cnt",     64'(a_fl),    64'd1);
    check("fl_bub",     64'(a_bub),   64'd1);
    check("fl_b_valid", 64'(b_valid), 64'd0);
    check("fl_b_pay",   b_pay,        64'h1234);
    check("fl_b_cnt",   64'(b_fl),    64'd1);

    // Five bubble cycles: a counts up, c (2-bit) saturates at 3
    flush = 1'b0; stall = 6'b011111;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("sat_a_bub", 64'(a_bub), 64'(1 + i));
      check("sat_c_bub", 64'(c_bub), 64'((1 + i) > 3 ? 3 : (1 + i)));
    end
    check("sat_a_fl", 64'(a_fl), 64'd1);

    // Advance with valid_i=0: write enables must be masked
    stall = 6'b000000; valid_i = 1'b0; ctrl_i = 4'hF; payload_i = 64'hABCD;
    tick();
    check("inv_valid", 64'(a_valid), 64'd0);
    check("inv_ctrl",  64'(a_ctrl),  64'd0);
    check("inv_pay",   a_pay,        64'hABCD);

    // Last stage bubbles on its own stall bit; stage 4 keeps advancing
    valid_i = 1'b1; ctrl_i = 4'h3; payload_i = 64'h55;
    tick();
    check("d_adv_ctrl", 64'(d_ctrl), 64'h3);
    stall = 6'b100000;
    tick();
    check("d_bub_valid", 64'(d_valid), 64'd0);
    check("d_bub_ctrl",  64'(d_ctrl),  64'd0);
    check("d_bub_pay",   d_pay,        64'd0);
    check("d_bub_cnt",   64'(d_bub),   64'd4);
    check("d_fl_cnt",    64'(d_fl),    64'd1);
    check("a_adv_valid", 64'(a_valid), 64'd1);
    check("a_adv_pay",   a_pay,        64'h55);
    check("a_adv_bub",   64'(a_bub),   64'd6);

    // Reset together with flush and bubble: reset wins, counters cleared
    rst = 1'b1; flush = 1'b1; stall = 6'b011111;
    tick();
    check("rst2_valid", 64'(a_valid), 64'd0);
    check("rst2_pay",   a_pay,        64'd0);
    check("rst2_b_pay", b_pay,        64'd0);
    check("rst2_bub",   64'(a_bub),   64'd0);
    check("rst2_fl",    64'(a_fl),    64'd0);
    check("rst2_c_bub", 64'(c_bub),   64'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
